// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, or runs one RAM load/store and stalls upstream until ack.
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES WAIT cycles with a bus_err pulse.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [15:0] Address,
    input  logic [15:0] storeData,
    input  logic [15:0] aluOutput,
    input  logic        writeRegp3,
    input  logic [2:0]  regAddressp3,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_re,
    output logic        ram_we,
    output logic [15:0] wbData,
    output logic        writeRegp4,
    output logic [2:0]  regAddressp4,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [15:0] alu_q, alu_d;
    logic        wreg_q, wreg_d;
    logic [2:0]  raddr_q, raddr_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        ram_re_q, ram_re_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        wreg_p4_q, wreg_p4_d;
    logic [2:0]  raddr_p4_q, raddr_p4_d;

    logic mem_req;
    assign mem_req = readEnable | writeEnable;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`else
    // A zero limit is meaningless; the check keeps the parameter referenced when no counter is built.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_cycles_zero
    end
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        alu_d       = alu_q;
        wreg_d      = wreg_q;
        raddr_d     = raddr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_re_d    = ram_re_q;
        ram_we_d    = ram_we_q;
        wb_data_d   = wb_data_q;
        wreg_p4_d   = wreg_p4_q;
        raddr_p4_d  = raddr_p4_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d     = ST_WAIT;
                    is_write_d  = writeEnable;
                    alu_d       = aluOutput;
                    wreg_d      = writeRegp3;
                    raddr_d     = regAddressp3;
                    ram_addr_d  = Address;
                    ram_wdata_d = storeData;
                    // A store takes priority when both enables are set.
                    ram_we_d    = writeEnable;
                    ram_re_d    = ~writeEnable;
                    wreg_p4_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else begin
                    wb_data_d   = aluOutput;
                    wreg_p4_d   = writeRegp3;
                    raddr_p4_d  = regAddressp3;
                end
            end

            ST_WAIT: begin
                if (ram_ack) begin
                    state_d    = ST_IDLE;
                    ram_re_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    wb_data_d  = is_write_q ? alu_q : ram_rdata;
                    wreg_p4_d  = wreg_q;
                    raddr_p4_d = raddr_q;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    ram_re_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    wreg_p4_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // the capture registers are reset too, so nothing from an abandoned access survives rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            alu_q       <= '0;
            wreg_q      <= 1'b0;
            raddr_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            wb_data_q   <= '0;
            wreg_p4_q   <= 1'b0;
            raddr_p4_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            alu_q       <= alu_d;
            wreg_q      <= wreg_d;
            raddr_q     <= raddr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            wb_data_q   <= wb_data_d;
            wreg_p4_q   <= wreg_p4_d;
            raddr_p4_q  <= raddr_p4_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_re       = ram_re_q;
    assign ram_we       = ram_we_q;
    assign wbData       = wb_data_q;
    assign writeRegp4   = wreg_p4_q;
    assign regAddressp4 = raddr_p4_q;
    assign stall        = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && mem_req);

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- readEnable  in  1  load request from execute stage.
- writeEnable  in  1  store request from execute stage.
- Address  in  16  data memory address.
- storeData  in  16  store data.
- aluOutput  in  16  ALU result from execute stage.
- writeRegp3  in  1  register write flag from execute stage.
- regAddressp3  in  3  destination register from execute stage.
- ram_rdata  in  16  read data from RAM, valid when ram_ack=1.
- ram_ack  in  1  RAM completion strobe.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- wbData  out  16  write-back data.
- writeRegp4  out  1  write-back register write enable.
- regAddressp4  out  3  write-back destination register.
- stall  out  1  hold request to upstream stages.
- bus_err  out  1  one-cycle timeout abort pulse.

Function
REQ-003 SHALL implement states IDLE and WAIT.
REQ-004 In IDLE with readEnable=0 and writeEnable=0, SHALL register the inputs one cycle later: wbData<=aluOutput, writeRegp4<=writeRegp3, regAddressp4<=regAddressp3.
REQ-005 In IDLE with readEnable or writeEnable set, SHALL capture Address, storeData, aluOutput, writeRegp3, regAddressp3 and the access type, then go to WAIT.
- If both enables are 1, the write wins and no read is issued.
REQ-006 On entry to WAIT, SHALL drive registered ram_addr and ram_wdata from the captured values.
- ram_re or ram_we SHALL go to 1 on the same edge and hold until the ack edge.
REQ-007 stall SHALL be combinational: 1 when (IDLE and (readEnable or writeEnable)) or WAIT; 0 otherwise.
REQ-008 While in WAIT, writeRegp4 SHALL be 0 (bubble); wbData and regAddressp4 SHALL hold their values.
REQ-009 In WAIT on ram_ack=1, SHALL return to IDLE and deassert ram_re/ram_we on the same edge.
- Load: wbData<=ram_rdata.
- Store: wbData<=captured aluOutput.
- Both: writeRegp4<=captured writeRegp3, regAddressp4<=captured regAddressp3.
REQ-010 ram_ack while in IDLE SHALL be ignored.
REQ-011 Minimum memory-access latency SHALL be 2 cycles from request to write-back valid (ack in the first WAIT cycle).
REQ-012 A new request SHALL be accepted in the IDLE cycle directly after ack, with no dead cycle.

Reset
REQ-013 rst=1 SHALL immediately force state IDLE and set all outputs to 0: wbData, writeRegp4, regAddressp4, ram_addr, ram_wdata, ram_re, ram_we, bus_err, and the timeout counter.
- stall SHALL follow REQ-007 from the IDLE state.
REQ-014 rst asserted during WAIT SHALL abandon the access with no write-back; a late ram_ack after reset SHALL be ignored.

Configuration
REQ-015 With macro MEM_TIMEOUT_EN defined, SHALL count WAIT cycles.
- If TIMEOUT_CYCLES cycles elapse without ram_ack: return to IDLE, deassert strobes, writeRegp4=0, and pulse bus_err=1 for one cycle.
- The counter SHALL clear on every WAIT entry.
- An ack in the same cycle the limit is reached SHALL win (normal completion, no bus_err).
REQ-016 Without MEM_TIMEOUT_EN, WAIT SHALL last until ram_ack; bus_err SHALL remain 0 and the counter SHALL not exist.

Verification
REQ-017 Non-memory instruction: aluOutput=0x1234, writeRegp3=1, regAddressp3=5 -> next cycle wbData=0x1234, writeRegp4=1, regAddressp4=5, stall=0.
REQ-018 Load: readEnable=1, Address=0x0040, ack after 3 wait cycles with ram_rdata=0xBEEF -> ram_re=1 for 3 cycles, stall=1 throughout, then wbData=0xBEEF, writeRegp4=1.
REQ-019 Store: writeEnable=1, Address=0x0010, storeData=0x00AA, immediate ack -> ram_we=1 for one cycle, ram_addr=0x0010, ram_wdata=0x00AA, writeRegp4=captured flag.
REQ-020 Back-to-back: load acked, then a store presented the next cycle -> store accepted with no idle gap; both operations complete in order.
REQ-021 Reset mid-WAIT: assert rst during a load, then ack -> all outputs 0, no write-back, state IDLE.
REQ-022 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack -> abort after 16 WAIT cycles, bus_err=1 for one cycle, writeRegp4=0, stall=0.
